sm_sum_table_writer: RTL



---
 rtl/sm_sum_table_writer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sm_sum_table_writer.sv
// rtl/sm_sum_table_writer.sv - fills a 256-entry sign-magnitude sum table, optionally reads it back and counts mismatches
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle pulse, accepted in IDLE or DONE
//   busy_o         high while filling / verifying
//   done_o         level, high in DONE
//   pass_o         high in DONE when no readback mismatches were seen
//   wr_en_o        table write request
//   wr_ready_i     table accepts the write this cycle
//   wr_addr_o      write address {x, y}
//   wr_data_o      sign-magnitude x + y
//   rd_en_o        readback request (memory has 1-cycle read latency)
//   rd_addr_o      readback address
//   rd_data_i      readback data, valid the cycle after rd_en_o
//   mismatch_cnt_o number of readback words that differed from expected

module sm_sum_table_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 5,
  parameter int VERIFY_EN  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  wr_en_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [8:0]            mismatch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  state;
  logic                    cmp_valid;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic [ADDR_WIDTH-1:0]   wr_addr_inc;
  logic [8:0]              mismatch_nxt;

  // Table word for address {x, y}: sign-magnitude addition of two 4-bit
  // sign-magnitude operands. A zero result is always encoded as +0.
  function automatic logic [DATA_WIDTH-1:0] sum_word(input logic [ADDR_WIDTH-1:0] a);
    logic                  sx, sy, sign;
    logic [2:0]            mx, my;
    logic [3:0]            mag;
    logic [DATA_WIDTH-1:0] res;
    sx = a[7];
    mx = a[6:4];
    sy = a[3];
    my = a[2:0];
    if (sx == sy) begin
      sign = sx;
      mag  = {1'b0, mx} + {1'b0, my};
    end else if (mx >= my) begin
      sign = sx;
      mag  = {1'b0, mx} - {1'b0, my};
    end else begin
      sign = sy;
      mag  = {1'b0, my} - {1'b0, mx};
    end
    res = '0;
    if (mag != 4'd0) begin
      res[DATA_WIDTH-1] = sign;
      res[3:0]          = mag;
    end
    return res;
  endfunction

  assign wr_addr_inc = wr_addr_o + ADDR_WIDTH'(1);

  // Compare stage: rd_data_i belongs to the address registered with the
  // previous cycle's rd_en_o.
  always_comb begin
    mismatch_nxt = mismatch_cnt_o;
    if (cmp_valid && (rd_data_i != sum_word(cmp_addr))) begin
      mismatch_nxt = mismatch_cnt_o + 9'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      rd_en_o        <= 1'b0;
      rd_addr_o      <= '0;
      mismatch_cnt_o <= '0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
    end else begin
      cmp_valid <= rd_en_o;
      cmp_addr  <= rd_addr_o;

      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state          <= WRITE;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            wr_en_o        <= 1'b1;
            wr_addr_o      <= '0;
            wr_data_o      <= sum_word('0);
            rd_addr_o      <= '0;
            mismatch_cnt_o <= '0;
          end
        end

        WRITE: begin
          // Address and data only move on a completed beat, so they stay
          // stable through any number of stall cycles.
          if (wr_ready_i) begin
            if (wr_addr_o == LAST_ADDR) begin
              wr_en_o <= 1'b0;
              if (VERIFY_EN != 0) begin
                state     <= VERIFY;
                rd_en_o   <= 1'b1;
                rd_addr_o <= '0;
              end else begin
                state  <= DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= (mismatch_cnt_o == 9'd0);
              end
            end else begin
              wr_addr_o <= wr_addr_inc;
              wr_data_o <= sum_word(wr_addr_inc);
            end
          end
        end

        VERIFY: begin
          mismatch_cnt_o <= mismatch_nxt;
          if (rd_en_o) begin
            if (rd_addr_o == LAST_ADDR) begin
              rd_en_o <= 1'b0;
            end else begin
              rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
            end
          end
          // The last compare lands one cycle after the last read request.
          if (cmp_valid && (cmp_addr == LAST_ADDR)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (mismatch_nxt == 9'd0);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
